// File: rtl/mux_nto1_scan_pkg.sv
// Shared definitions for the N:1 scanning multiplexer: FSM state encoding and a
// ceil(log2) helper used to size the select and counter fields.
package mux_nto1_scan_pkg;

   typedef enum logic {
      StManual = 1'b0,
      StScan   = 1'b1
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = unsigned'(i + 1);
      end
      return res;
   endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Purely combinational indexed selector; yields zero data and flags any index
// that does not name an existing channel.
module mux_nto1_comb
   import mux_nto1_scan_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DW     = 1,
   localparam int unsigned SELW  = clog2(NUM_CH)
) (
   input  logic [NUM_CH*DW-1:0] in_data,
   input  logic [SELW-1:0]      idx,
   output logic [DW-1:0]        data,
   output logic                 oor
);

   always_comb begin
      data = '0;
      oor  = 1'b1;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (idx == SELW'(k)) begin
            data = in_data[k*DW +: DW];
            oor  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N:1 multiplexer with a MANUAL (sel-driven) mode and a SCAN mode that
// steps through every channel, holding each for DWELL clocks.
module mux_nto1_scan
   import mux_nto1_scan_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DW     = 1,
   parameter int unsigned DWELL  = 4,
   localparam int unsigned SELW  = clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_CH*DW-1:0] in_data,
   input  logic [SELW-1:0]      sel,
   input  logic                 mode,
   input  logic                 hold,
   output logic [DW-1:0]        out,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   output logic                 scan_wrap
);

   localparam int unsigned DWW = (DWELL > 1) ? clog2(DWELL) : 1;

   state_e          state_q, state_d;
   logic [SELW-1:0] ch_cnt_q, ch_cnt_d;
   logic [DWW-1:0]  dw_cnt_q, dw_cnt_d;

   logic [SELW-1:0] idx;
   logic [DW-1:0]   mux_data;
   logic            mux_oor;

   logic [DW-1:0]   out_d;
   logic [SELW-1:0] out_ch_d;
   logic            out_valid_d;
   logic            scan_wrap_d;

   always_comb begin
      idx = (state_q == StScan) ? ch_cnt_q : sel;
   end

   mux_nto1_comb #(
      .NUM_CH (NUM_CH),
      .DW     (DW)
   ) u_sel (
      .in_data (in_data),
      .idx     (idx),
      .data    (mux_data),
      .oor     (mux_oor)
   );

   // Outputs follow the current state's rules even on the edge that changes state.
   always_comb begin
      state_d     = mode ? StScan : StManual;
      ch_cnt_d    = '0;
      dw_cnt_d    = '0;
      scan_wrap_d = 1'b0;
      out_d       = mux_data;
      out_ch_d    = idx;
      out_valid_d = ~mux_oor;
      unique case (state_q)
         StManual: begin
            // Counters held at zero so every SCAN entry starts on channel 0.
            ch_cnt_d = '0;
            dw_cnt_d = '0;
         end
         StScan: begin
            ch_cnt_d = ch_cnt_q;
            dw_cnt_d = dw_cnt_q;
            if (!hold) begin
               if (dw_cnt_q == DWW'(DWELL - 1)) begin
                  dw_cnt_d = '0;
                  if (ch_cnt_q == SELW'(NUM_CH - 1)) begin
                     ch_cnt_d    = '0;
                     scan_wrap_d = 1'b1;
                  end else begin
                     ch_cnt_d = ch_cnt_q + SELW'(1);
                  end
               end else begin
                  dw_cnt_d = dw_cnt_q + DWW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StManual;
         ch_cnt_q  <= '0;
         dw_cnt_q  <= '0;
         out       <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         scan_wrap <= 1'b0;
      end else begin
         state_q   <= state_d;
         ch_cnt_q  <= ch_cnt_d;
         dw_cnt_q  <= dw_cnt_d;
         out       <= out_d;
         out_ch    <= out_ch_d;
         out_valid <= out_valid_d;
         scan_wrap <= scan_wrap_d;
      end
   end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Bench for mux_nto1_scan: a 5-channel/DWELL=2 instance and a 4-channel/DWELL=1
// instance checked against a position-counting reference model.
module tb_mux_nto1_scan;

   logic        clk = 1'b0;
   logic        rst_n, mode, hold;
   logic [2:0]  sel_a;
   logic [1:0]  sel_b;
   logic [39:0] in_a;
   logic [31:0] in_b;
   logic [7:0]  out_a, out_b;
   logic [2:0]  out_ch_a;
   logic [1:0]  out_ch_b;
   logic        valid_a, valid_b, wrap_a, wrap_b;

   logic [7:0]  ch_a [5];
   logic [7:0]  ch_b [4];

   int checks   = 0;
   int failures = 0;

   // Model: scan position = number of un-held SCAN clocks since entry.
   bit          ma_scan, mb_scan;
   int          ma_t, mb_t;
   logic [7:0]  ea_out, eb_out;
   logic [2:0]  ea_ch;
   logic [1:0]  eb_ch;
   logic        ea_v, eb_v, ea_w, eb_w;

   always #5 clk = ~clk;

   mux_nto1_scan #(.NUM_CH(5), .DW(8), .DWELL(2)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_a),
      .sel       (sel_a),
      .mode      (mode),
      .hold      (hold),
      .out       (out_a),
      .out_ch    (out_ch_a),
      .out_valid (valid_a),
      .scan_wrap (wrap_a)
   );

   mux_nto1_scan #(.NUM_CH(4), .DW(8), .DWELL(1)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_b),
      .sel       (sel_b),
      .mode      (mode),
      .hold      (hold),
      .out       (out_b),
      .out_ch    (out_ch_b),
      .out_valid (valid_b),
      .scan_wrap (wrap_b)
   );

   task automatic set_base();
      for (int k = 0; k < 5; k++) ch_a[k] = 8'hA0 + 8'(k);
      for (int k = 0; k < 4; k++) ch_b[k] = 8'hA0 + 8'(k);
   endtask

   task automatic rand_data();
      for (int k = 0; k < 5; k++) ch_a[k] = 8'($urandom);
      for (int k = 0; k < 4; k++) ch_b[k] = 8'($urandom);
   endtask

   // Apply current inputs, predict the registered result, advance one clock.
   task automatic tick();
      for (int k = 0; k < 5; k++) in_a[k*8 +: 8] = ch_a[k];
      for (int k = 0; k < 4; k++) in_b[k*8 +: 8] = ch_b[k];
      if (!rst_n) begin
         ma_scan = 0; ma_t = 0; mb_scan = 0; mb_t = 0;
         ea_out = '0; ea_ch = '0; ea_v = 0; ea_w = 0;
         eb_out = '0; eb_ch = '0; eb_v = 0; eb_w = 0;
      end else begin
         if (ma_scan) begin
            ea_ch  = 3'((ma_t / 2) % 5);
            ea_out = ch_a[ea_ch];
            ea_v   = 1;
            ea_w   = !hold && (ma_t % 10 == 9);
            if (!hold) ma_t++;
         end else begin
            ea_ch = sel_a;
            ea_w  = 0;
            if (sel_a < 5) begin ea_v = 1; ea_out = ch_a[sel_a]; end
            else begin ea_v = 0; ea_out = '0; end
         end
         if (mode && !ma_scan) ma_t = 0;
         ma_scan = mode;
         if (mb_scan) begin
            eb_ch  = 2'(mb_t % 4);
            eb_out = ch_b[eb_ch];
            eb_v   = 1;
            eb_w   = !hold && (mb_t % 4 == 3);
            if (!hold) mb_t++;
         end else begin
            eb_ch  = sel_b;
            eb_out = ch_b[sel_b];
            eb_v   = 1;
            eb_w   = 0;
         end
         if (mode && !mb_scan) mb_t = 0;
         mb_scan = mode;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) begin
         mode = 1'($urandom); hold = 1'($urandom);
         sel_a = 3'($urandom); sel_b = 2'($urandom);
         rand_data();
         tick();
         checks++;
         if ({out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b, valid_b, wrap_b} !== '0) begin
            failures++;
            $display("FAIL reset_hold: got a=%h/%0d/%b/%b b=%h/%0d/%b/%b required all zero",
                     out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b, valid_b, wrap_b);
         end
      end
      set_base();
      rst_n = 1'b1; mode = 1'b0; hold = 1'b0; sel_a = 3'd3; sel_b = 2'd0;
      tick();
      checks++;
      if ({out_a, out_ch_a, valid_a, wrap_a} !== {8'hA3, 3'd3, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL reset_release: got %h/%0d/%b/%b required a3/3/1/0",
                  out_a, out_ch_a, valid_a, wrap_a);
      end
   endtask

   task automatic test_manual();
      sel_a = 3'd6;
      tick();
      checks++;
      if ({out_a, out_ch_a, valid_a, wrap_a} !== {8'h00, 3'd6, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL manual_oor: got %h/%0d/%b/%b required 00/6/0/0",
                  out_a, out_ch_a, valid_a, wrap_a);
      end
      sel_a = 3'd4;
      tick();
      checks++;
      if ({out_a, out_ch_a, valid_a} !== {8'hA4, 3'd4, 1'b1}) begin
         failures++;
         $display("FAIL manual_sel4: got %h/%0d/%b required a4/4/1", out_a, out_ch_a, valid_a);
      end
      for (int i = 0; i < 20; i++) begin
         sel_a = 3'($urandom); sel_b = 2'($urandom); hold = 1'($urandom);
         rand_data();
         tick();
         checks++;
         if ({out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b, valid_b, wrap_b} !==
             {ea_out, ea_ch, ea_v, ea_w, eb_out, eb_ch, eb_v, eb_w}) begin
            failures++;
            $display("FAIL manual_rand[%0d]: got %h/%0d/%b/%b %h/%0d/%b/%b required %h/%0d/%b/%b %h/%0d/%b/%b",
                     i, out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b, valid_b, wrap_b,
                     ea_out, ea_ch, ea_v, ea_w, eb_out, eb_ch, eb_v, eb_w);
         end
      end
   endtask

   task automatic test_scan_sequence();
      int exp_seq [20] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0, 1, 1, 2, 2, 3, 3, 4, 4};
      set_base();
      hold = 1'b0; sel_a = 3'd2;
      mode = 1'b1;
      tick();
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({out_ch_a, wrap_a, out_a, valid_a} !==
             {3'(exp_seq[i]), 1'(i == 9 || i == 19), 8'hA0 + 8'(exp_seq[i]), 1'b1}) begin
            failures++;
            $display("FAIL scan_seq[%0d]: got ch=%0d wrap=%b out=%h v=%b required ch=%0d wrap=%b",
                     i, out_ch_a, wrap_a, out_a, valid_a, exp_seq[i], (i == 9 || i == 19));
         end
      end
   endtask

   task automatic test_hold();
      int exp_after [3] = '{2, 2, 3};
      set_base();
      mode = 1'b0; hold = 1'b0;
      tick();
      mode = 1'b1;
      tick();
      repeat (4) tick();
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) ch_a[2] = 8'h55;
         tick();
         checks++;
         if ({out_ch_a, wrap_a, out_a} !== {3'd2, 1'b0, (i >= 1) ? 8'h55 : 8'hA2}) begin
            failures++;
            $display("FAIL hold[%0d]: got ch=%0d wrap=%b out=%h required ch=2 wrap=0 out=%h",
                     i, out_ch_a, wrap_a, out_a, (i >= 1) ? 8'h55 : 8'hA2);
         end
      end
      hold = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out_ch_a !== 3'(exp_after[i])) begin
            failures++;
            $display("FAIL hold_resume[%0d]: got ch=%0d required %0d", i, out_ch_a, exp_after[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         hold  = ($urandom_range(0, 3) == 0);
         sel_a = 3'($urandom); sel_b = 2'($urandom);
         if ($urandom_range(0, 1) == 0) rand_data();
         tick();
         checks++;
         if ({out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b, valid_b, wrap_b} !==
             {ea_out, ea_ch, ea_v, ea_w, eb_out, eb_ch, eb_v, eb_w}) begin
            failures++;
            $display("FAIL random[%0d]: got %h/%0d/%b/%b %h/%0d/%b/%b required %h/%0d/%b/%b %h/%0d/%b/%b",
                     i, out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b, valid_b, wrap_b,
                     ea_out, ea_ch, ea_v, ea_w, eb_out, eb_ch, eb_v, eb_w);
         end
      end
   endtask

   task automatic test_dwell1();
      set_base();
      hold = 1'b0; mode = 1'b0;
      tick();
      mode = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({out_ch_b, wrap_b, out_b} !== {2'(i % 4), 1'(i % 4 == 3), 8'hA0 + 8'(i % 4)}) begin
            failures++;
            $display("FAIL dwell1[%0d]: got ch=%0d wrap=%b out=%h required ch=%0d wrap=%b",
                     i, out_ch_b, wrap_b, out_b, i % 4, (i % 4 == 3));
         end
      end
      mode = 1'b0; sel_b = 2'd2;
      tick();
      checks++;
      if ({out_b, out_ch_b, wrap_b} !== {eb_out, eb_ch, eb_w}) begin
         failures++;
         $display("FAIL dwell1_exit_edge: got %h/%0d/%b required %h/%0d/%b",
                  out_b, out_ch_b, wrap_b, eb_out, eb_ch, eb_w);
      end
      tick();
      checks++;
      if ({out_b, out_ch_b, valid_b} !== {8'hA2, 2'd2, 1'b1}) begin
         failures++;
         $display("FAIL dwell1_manual: got %h/%0d/%b required a2/2/1", out_b, out_ch_b, valid_b);
      end
      mode = 1'b1;
      tick();
      tick();
      checks++;
      if (out_ch_b !== 2'd0 || out_b !== 8'hA0) begin
         failures++;
         $display("FAIL dwell1_reentry: got ch=%0d out=%h required ch=0 out=a0", out_ch_b, out_b);
      end
   endtask

   task automatic test_async_reset();
      set_base();
      mode = 1'b1; hold = 1'b0;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b, valid_b, wrap_b} !== '0) begin
         failures++;
         $display("FAIL async_reset: got a=%h/%0d/%b/%b b=%h/%0d/%b/%b required all zero",
                  out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b, valid_b, wrap_b);
      end
      tick();
      rst_n = 1'b1; mode = 1'b0; sel_a = 3'd1; sel_b = 2'd3;
      tick();
      checks++;
      if ({out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b} !==
          {8'hA1, 3'd1, 1'b1, 1'b0, 8'hA3, 2'd3}) begin
         failures++;
         $display("FAIL async_release: got a=%h/%0d/%b/%b b=%h/%0d required a1/1/1/0 a3/3",
                  out_a, out_ch_a, valid_a, wrap_a, out_b, out_ch_b);
      end
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b0; hold = 1'b0; sel_a = '0; sel_b = '0;
      set_base();
      in_a = '0; in_b = '0;
      ma_scan = 0; mb_scan = 0; ma_t = 0; mb_t = 0;
      #1;
      test_reset();
      test_manual();
      test_scan_sequence();
      test_hold();
      test_random();
      test_dwell1();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
